// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with a valid/ready output register and per-word error flags.
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 majority vote around each sample point).
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int H  = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] BIT_SP    = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q;
  logic [CW-1:0]          clk_cnt_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   perr_q;
  logic                   ferr_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   rx_meta_q;
  logic                   rxs_q;
  logic                   bit_s;
  logic                   at_sp;

  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   parity_err_q;
  logic                   frame_err_q;
  logic                   overrun_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Decisions move one cycle later so the vote can include the sample after the nominal point.
  localparam logic [CW-1:0] START_SP = CW'(H);
  logic [1:0] hist_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) hist_q <= 2'b11;
    else         hist_q <= {hist_q[0], rxs_q};
  end

  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
  localparam logic [CW-1:0] START_SP = CW'(H - 1);
  assign bit_s = rxs_q;
`endif

  assign at_sp = (state_q == START) ? (clk_cnt_q == START_SP) : (clk_cnt_q == BIT_SP);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) clk_cnt_q <= at_sp ? '0 : clk_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_q   <= START;
            clk_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (at_sp) begin
            if (bit_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              bit_cnt_q <= '0;
              state_q   <= DATA;
            end
          end
        end
        DATA: begin
          if (at_sp) begin
            shift_q   <= {bit_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
              perr_q    <= 1'b0;
              ferr_q    <= 1'b0;
              state_q   <= (PARITY_MODE != 0) ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (at_sp) begin
            perr_q  <= (PARITY_MODE == 2) ? ~(^shift_q ^ bit_s) : (^shift_q ^ bit_s);
            state_q <= STOP;
          end
        end
        STOP: begin
          if (at_sp) begin
            ferr_q    <= ferr_q | ~bit_s;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            // Leave at the centre of the last stop bit so a following start edge is not missed.
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_q <= '0;
              done_q    <= 1'b1;
              state_q   <= IDLE;
              busy_q    <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done_q) begin
        if (!rx_valid_q || rx_ready_i) begin
          rx_data_q    <= shift_q;
          parity_err_q <= perr_q;
          frame_err_q  <= ferr_q;
          rx_valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed frames plus randomized traffic against a
// frame-level reference model of the output register.
module tb_uart_rx_param;

  localparam int CPB       = 16;
  localparam int DBITS     = 8;
  localparam int PMODE     = 1;
  localparam int SBITS     = 1;
  localparam int HALF      = CPB / 2;
  localparam int NBITS     = DBITS + ((PMODE != 0) ? 1 : 0) + SBITS;
  localparam int LAT       = 2 + HALF + NBITS * CPB + 1;
  localparam int LOGLEN    = 32768;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             rx_i = 1'b1;
  logic             rx_ready_i = 1'b1;
  logic [DBITS-1:0] rx_data_o;
  logic             rx_valid_o;
  logic             parity_err_o;
  logic             frame_err_o;
  logic             overrun_o;
  logic             busy_o;

  typedef struct {
    int               loadCycle;
    logic [DBITS-1:0] data;
    logic             perr;
    logic             ferr;
  } frame_t;

  frame_t           expQ[$];
  frame_t           headFrame;
  int               cycle = 0;
  int               checks = 0;
  int               failures = 0;
  int               readyMode = 1;
  int               overrunSeen = 0;
  int               lastRise = -1;
  bit               monOn = 1'b0;
  bit               prevValid = 1'b0;
  bit               busyLog[LOGLEN];
  bit               validLog[LOGLEN];
  logic             mValid = 1'b0;
  logic [DBITS-1:0] mData = '0;
  logic             mPerr = 1'b0;
  logic             mFerr = 1'b0;
  logic             mOverrun = 1'b0;
  logic             handshake;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DBITS),
    .PARITY_MODE (PMODE),
    .STOP_BITS   (SBITS)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .parity_err_o(parity_err_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle <= cycle + 1;

  // Consumer: fixed low, fixed high, or random acceptance, updated just after each edge.
  always @(posedge clk_i) begin
    #2;
    case (readyMode)
      0:       rx_ready_i = 1'b0;
      1:       rx_ready_i = 1'b1;
      default: rx_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at cycle %0d", tag, observed, expected, cycle);
    end
  endtask

  // Compare against the model, then advance the model to the next edge using the current inputs.
  always @(negedge clk_i) begin
    if (cycle < LOGLEN) begin
      busyLog[cycle]  = busy_o;
      validLog[cycle] = rx_valid_o;
    end
    if (rx_valid_o === 1'b1 && !prevValid) lastRise = cycle;
    prevValid = (rx_valid_o === 1'b1);
    if (overrun_o === 1'b1) overrunSeen++;
    if (monOn) begin
      checkOutput("rx_valid",   32'(rx_valid_o),   32'(mValid));
      checkOutput("rx_data",    32'(rx_data_o),    32'(mData));
      checkOutput("parity_err", 32'(parity_err_o), 32'(mPerr));
      checkOutput("frame_err",  32'(frame_err_o),  32'(mFerr));
      checkOutput("overrun",    32'(overrun_o),    32'(mOverrun));
    end
    mOverrun = 1'b0;
    if (reset_i) begin
      mValid = 1'b0;
      mData  = '0;
      mPerr  = 1'b0;
      mFerr  = 1'b0;
      expQ.delete();
    end else begin
      handshake = mValid && rx_ready_i;
      if (expQ.size() > 0 && expQ[0].loadCycle <= cycle + 1) begin
        headFrame = expQ.pop_front();
        if (!mValid || handshake) begin
          mValid = 1'b1;
          mData  = headFrame.data;
          mPerr  = headFrame.perr;
          mFerr  = headFrame.ferr;
        end else begin
          mOverrun = 1'b1;
        end
      end else if (handshake) begin
        mValid = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic idleLine(input int n);
    rx_i = 1'b1;
    step(n);
  endtask

  // Serialises one frame (start, data LSB first, parity, stops); a truncated frame predicts nothing.
  task automatic applyStimulus(input logic [DBITS-1:0] data, input bit badParity, input bit badStop,
                               input int maxBits, output int t1);
    bit     lineBits[$];
    frame_t f;
    lineBits.push_back(1'b0);
    for (int i = 0; i < DBITS; i++) lineBits.push_back(data[i]);
    if (PMODE != 0) lineBits.push_back((^data) ^ (PMODE == 2) ^ badParity);
    for (int s = 0; s < SBITS; s++) lineBits.push_back(!(badStop && s == 0));
    t1 = cycle + 1;
    if (maxBits >= lineBits.size()) begin
      f.loadCycle = t1 + LAT;
      f.data      = data;
      f.perr      = (PMODE != 0) && badParity;
      f.ferr      = badStop;
      expQ.push_back(f);
    end
    for (int b = 0; b < lineBits.size() && b < maxBits; b++) begin
      rx_i = lineBits[b];
      step(CPB);
    end
  endtask

  initial begin
    int t1;
    int riseBefore;
    int ovBefore;
    logic [DBITS-1:0] rdata;
    bit bp;
    bit bs;

    reset_i = 1'b1;
    rx_i    = 1'b1;
    step(3);
    reset_i = 1'b0;
    monOn   = 1'b1;
    @(negedge clk_i);
    checkOutput("reset rx_valid", 32'(rx_valid_o), 32'd0);
    checkOutput("reset rx_data",  32'(rx_data_o),  32'd0);
    checkOutput("reset busy",     32'(busy_o),     32'd0);
    checkOutput("reset overrun",  32'(overrun_o),  32'd0);
    step(1);

    // Good 0xA5 frame: latency, one-cycle valid with ready high, busy window.
    applyStimulus(8'hA5, 1'b0, 1'b0, 99, t1);
    checkOutput("A5 rise cycle",     32'(lastRise - t1), 32'(LAT));
    checkOutput("A5 valid before",   32'(validLog[t1+LAT-1]), 32'd0);
    checkOutput("A5 valid at",       32'(validLog[t1+LAT]),   32'd1);
    checkOutput("A5 valid after",    32'(validLog[t1+LAT+1]), 32'd0);
    checkOutput("A5 busy pre",       32'(busyLog[t1+1]),      32'd0);
    checkOutput("A5 busy start",     32'(busyLog[t1+2]),      32'd1);
    checkOutput("A5 busy last",      32'(busyLog[t1+LAT-2]),  32'd1);
    checkOutput("A5 busy end",       32'(busyLog[t1+LAT-1]),  32'd0);
    checkOutput("A5 data",           32'(rx_data_o),    32'h0A5);
    checkOutput("A5 parity_err",     32'(parity_err_o), 32'd0);
    checkOutput("A5 frame_err",      32'(frame_err_o),  32'd0);

    // Same word with the parity bit inverted.
    applyStimulus(8'hA5, 1'b1, 1'b0, 99, t1);
    checkOutput("A5 badpar data",       32'(rx_data_o),    32'h0A5);
    checkOutput("A5 badpar parity_err", 32'(parity_err_o), 32'd1);
    checkOutput("A5 badpar frame_err",  32'(frame_err_o),  32'd0);

    // Framing error, then recovery on a clean frame.
    applyStimulus(8'h3C, 1'b0, 1'b1, 99, t1);
    checkOutput("3C data",      32'(rx_data_o),   32'h03C);
    checkOutput("3C frame_err", 32'(frame_err_o), 32'd1);
    idleLine(2 * CPB);
    applyStimulus(8'h5A, 1'b0, 1'b0, 99, t1);
    checkOutput("5A data",      32'(rx_data_o),   32'h05A);
    checkOutput("5A frame_err", 32'(frame_err_o), 32'd0);

    // False start: four low cycles.
    idleLine(CPB);
    riseBefore = lastRise;
    t1   = cycle + 1;
    rx_i = 1'b0;
    step(4);
    idleLine(3 * CPB);
    checkOutput("false start no valid", 32'(lastRise), 32'(riseBefore));
    checkOutput("false start busy on",  32'(busyLog[t1+2]),  32'd1);
    checkOutput("false start busy mid", 32'(busyLog[t1+9]),  32'd1);
    checkOutput("false start busy off", 32'(busyLog[t1+10]), 32'd0);

    // Overrun: consumer stalled, two back-to-back frames.
    readyMode = 0;
    idleLine(4);
    ovBefore = overrunSeen;
    applyStimulus(8'h11, 1'b0, 1'b0, 99, t1);
    applyStimulus(8'h22, 1'b0, 1'b0, 99, t1);
    checkOutput("overrun pulses",  32'(overrunSeen - ovBefore), 32'd1);
    checkOutput("overrun data",    32'(rx_data_o),  32'h011);
    checkOutput("overrun valid",   32'(rx_valid_o), 32'd1);
    readyMode = 1;
    step(1);
    readyMode = 0;
    step(1);
    @(negedge clk_i);
    checkOutput("drain valid", 32'(rx_valid_o), 32'd0);
    checkOutput("drain data",  32'(rx_data_o),  32'h011);
    step(1);

    // Hold a flagged word, then reset mid-frame and receive a fresh one.
    applyStimulus(8'h33, 1'b1, 1'b0, 99, t1);
    checkOutput("33 held valid", 32'(rx_valid_o), 32'd1);
    applyStimulus(8'h96, 1'b0, 1'b0, 4, t1);
    reset_i = 1'b1;
    rx_i    = 1'b1;
    step(1);
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("midreset rx_valid",   32'(rx_valid_o),   32'd0);
    checkOutput("midreset rx_data",    32'(rx_data_o),    32'd0);
    checkOutput("midreset parity_err", 32'(parity_err_o), 32'd0);
    checkOutput("midreset frame_err",  32'(frame_err_o),  32'd0);
    checkOutput("midreset overrun",    32'(overrun_o),    32'd0);
    checkOutput("midreset busy",       32'(busy_o),       32'd0);
    step(1);
    readyMode = 1;
    idleLine(10);
    applyStimulus(8'h7E, 1'b0, 1'b0, 99, t1);
    checkOutput("7E data",       32'(rx_data_o),    32'h07E);
    checkOutput("7E parity_err", 32'(parity_err_o), 32'd0);
    checkOutput("7E frame_err",  32'(frame_err_o),  32'd0);

    // Randomized traffic with a randomly stalling consumer.
    readyMode = 2;
    for (int k = 0; k < 25; k++) begin
      rdata = DBITS'($urandom_range(0, (1 << DBITS) - 1));
      bp    = ($urandom_range(0, 5) == 0);
      bs    = ($urandom_range(0, 5) == 0);
      applyStimulus(rdata, bp, bs, 99, t1);
      if (bs) idleLine(CPB + $urandom_range(0, 20));
      else    idleLine($urandom_range(0, 20));
    end
    readyMode = 1;
    idleLine(4 * CPB);
    checkOutput("all frames delivered", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk_i);
    $display("[TB] FAIL watchdog: cycle=%0d limit=60000", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
